// File: rtl/seq_multiplier_if.sv
// Operand/result handshake bundle for the sequential multiplier.
// master = operand producer / result consumer side; slave = multiplier side.
// Both directions use valid/ready; a transfer happens when both are high at a clock edge.
interface seq_multiplier_if #(
    parameter int SIZE = 4
);
    logic                in_valid;
    logic                in_ready;
    logic [SIZE-1:0]     x;
    logic [SIZE-1:0]     y;
    logic                sgn;
    logic                out_valid;
    logic                out_ready;
    logic [2*SIZE-1:0]   p;

    modport master (
        output in_valid, x, y, sgn, out_ready,
        input  in_ready, out_valid, p
    );

    modport slave (
        input  in_valid, x, y, sgn, out_ready,
        output in_ready, out_valid, p
    );
endinterface

// File: rtl/seq_multiplier.sv
// Iterative SIZE x SIZE shift-add multiplier, unsigned or two's-complement per operation.
// Latency: out_valid rises SIZE cycles after the accept edge; one operation in flight.
// Backpressure: in_ready only in IDLE; result and out_valid held in DONE until out_ready.
module seq_multiplier #(
    parameter int SIZE = 4
) (
    input  logic              clk,
    input  logic              reset,
    seq_multiplier_if.slave   bus
);
    localparam int CW = $clog2(SIZE + 1);
    localparam int W  = 2 * SIZE;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [W-1:0]    mcand_q, mcand_d;
    logic [SIZE-1:0] mplier_q, mplier_d;
    logic [W-1:0]    acc_q, acc_d;
    logic [W-1:0]    p_q, p_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            neg_q, neg_d;

    logic [SIZE-1:0] x_mag;
    logic [SIZE-1:0] y_mag;
    logic [W-1:0]    acc_sum;

    // Operand magnitudes (the most negative value maps to 2^(SIZE-1), which still fits)
    // and the accumulator value after the current iteration's conditional add.
    always_comb begin
        x_mag   = (bus.sgn && bus.x[SIZE-1]) ? -bus.x : bus.x;
        y_mag   = (bus.sgn && bus.y[SIZE-1]) ? -bus.y : bus.y;
        acc_sum = acc_q + (mplier_q[0] ? mcand_q : '0);
    end

    // Next-state and datapath control: accept in IDLE, SIZE shift-add steps in RUN,
    // hold the result in DONE until the consumer takes it.
    always_comb begin
        state_d  = state_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        p_d      = p_q;
        cnt_d    = cnt_q;
        neg_d    = neg_q;
        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    mcand_d  = {{SIZE{1'b0}}, x_mag};
                    mplier_d = y_mag;
                    neg_d    = bus.sgn & (bus.x[SIZE-1] ^ bus.y[SIZE-1]);
                    acc_d    = '0;
                    cnt_d    = '0;
                    state_d  = RUN;
                end
            end
            RUN: begin
                acc_d    = acc_sum;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + CW'(1);
                if (cnt_q == CW'(SIZE - 1)) begin
                    // Sign is applied once on the full magnitude product; -0 stays 0.
                    p_d     = neg_q ? -acc_sum : acc_sum;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset discards any in-flight operation.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            p_q      <= '0;
            cnt_q    <= '0;
            neg_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            p_q      <= p_d;
            cnt_q    <= cnt_d;
            neg_q    <= neg_d;
        end
    end

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = (state_q == DONE);
    assign bus.p         = p_q;
endmodule

// File: tb/tb_seq_multiplier.sv
// Directed bench for seq_multiplier at SIZE = 4, 8 and 5 (exhaustive at 5).
// Inputs change and outputs are sampled on the falling clock edge.
// Every expected value below is hand-computed or derived from plain integer math.
module tb_seq_multiplier;
    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    seq_multiplier_if #(.SIZE(4)) b4 ();
    seq_multiplier_if #(.SIZE(8)) b8 ();
    seq_multiplier_if #(.SIZE(5)) b5 ();

    seq_multiplier #(.SIZE(4)) dut4 (.clk(clk), .reset(reset), .bus(b4));
    seq_multiplier #(.SIZE(8)) dut8 (.clk(clk), .reset(reset), .bus(b8));
    seq_multiplier #(.SIZE(5)) dut5 (.clk(clk), .reset(reset), .bus(b5));

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input int sel, input logic [7:0] xv, input logic [7:0] yv,
                         input logic s, input logic v);
        case (sel)
            4: begin b4.x = xv[3:0]; b4.y = yv[3:0]; b4.sgn = s; b4.in_valid = v; end
            8: begin b8.x = xv;      b8.y = yv;      b8.sgn = s; b8.in_valid = v; end
            default: begin b5.x = xv[4:0]; b5.y = yv[4:0]; b5.sgn = s; b5.in_valid = v; end
        endcase
    endtask

    function automatic logic rdy(input int sel);
        case (sel)
            4:       return b4.in_ready;
            8:       return b8.in_ready;
            default: return b5.in_ready;
        endcase
    endfunction

    function automatic logic ovld(input int sel);
        case (sel)
            4:       return b4.out_valid;
            8:       return b8.out_valid;
            default: return b5.out_valid;
        endcase
    endfunction

    function automatic logic [15:0] pval(input int sel);
        case (sel)
            4:       return 16'(b4.p);
            8:       return b8.p;
            default: return 16'(b5.p);
        endcase
    endfunction

    // Present operands, wait for acceptance, then count cycles until out_valid.
    // Returns at the falling edge where out_valid is first seen high.
    task automatic op(input int sel, input logic [7:0] xv, input logic [7:0] yv, input logic s,
                      output logic [15:0] pr, output int lat);
        int n;
        drive(sel, xv, yv, s, 1'b1);
        n = 0;
        while (!rdy(sel) && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) chk("accept_timeout", 32'(n), 32'(0));
        @(negedge clk);
        drive(sel, xv, yv, s, 1'b0);
        lat = 0;
        while (!ovld(sel) && lat < 50) begin
            @(negedge clk);
            lat++;
        end
        pr = pval(sel);
    endtask

    logic [15:0] pr;
    int          lat;
    int          xs, ys, ev;

    initial begin
        reset        = 1'b1;
        drive(4, 8'd0, 8'd0, 1'b0, 1'b0);
        drive(8, 8'd0, 8'd0, 1'b0, 1'b0);
        drive(5, 8'd0, 8'd0, 1'b0, 1'b0);
        b4.out_ready = 1'b0;
        b8.out_ready = 1'b0;
        b5.out_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        // Reset state, no stimulus
        chk("rst_in_ready",  32'(b4.in_ready),  32'd1);
        chk("rst_out_valid", 32'(b4.out_valid), 32'd0);
        chk("rst_p",         32'(b4.p),         32'h00);

        // Unsigned 15*15, latency and return to IDLE
        b4.out_ready = 1'b1;
        op(4, 8'd15, 8'd15, 1'b0, pr, lat);
        chk("u15x15_p",   32'(pr),  32'hE1);
        chk("u15x15_lat", 32'(lat), 32'd4);
        @(negedge clk);
        chk("u15x15_ov_drop",   32'(b4.out_valid), 32'd0);
        chk("u15x15_ready_back", 32'(b4.in_ready), 32'd1);

        // Signed corner cases: -8*-8, -8*7, 0*-3
        op(4, 8'h08, 8'h08, 1'b1, pr, lat);
        chk("s_m8xm8_p",   32'(pr),  32'h40);
        chk("s_m8xm8_lat", 32'(lat), 32'd4);
        op(4, 8'h08, 8'h07, 1'b1, pr, lat);
        chk("s_m8x7_p", 32'(pr), 32'hC8);
        op(4, 8'h00, 8'h0D, 1'b1, pr, lat);
        chk("s_0xm3_p", 32'(pr), 32'h00);
        @(negedge clk);

        // Output backpressure: result held, new operands not accepted
        b4.out_ready = 1'b0;
        op(4, 8'd3, 8'd5, 1'b0, pr, lat);
        chk("hold_first_p", 32'(pr), 32'h0F);
        drive(4, 8'd6, 8'd7, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("hold_ov",       32'(b4.out_valid), 32'd1);
            chk("hold_p",        32'(b4.p),         32'h0F);
            chk("hold_in_ready", 32'(b4.in_ready),  32'd0);
        end
        b4.out_ready = 1'b1;
        @(negedge clk);
        chk("release_ov",       32'(b4.out_valid), 32'd0);
        chk("release_in_ready", 32'(b4.in_ready),  32'd1);
        @(negedge clk);
        chk("release_accepted", 32'(b4.in_ready), 32'd0);
        drive(4, 8'd6, 8'd7, 1'b0, 1'b0);
        lat = 0;
        while (!b4.out_valid && lat < 50) begin
            @(negedge clk);
            lat++;
        end
        chk("release_p",   32'(b4.p), 32'h2A);
        chk("release_lat", 32'(lat),  32'd4);

        // SIZE=8: reset two cycles into RUN discards the operation
        b8.out_ready = 1'b1;
        drive(8, 8'd200, 8'd3, 1'b0, 1'b1);
        @(negedge clk);
        drive(8, 8'd200, 8'd3, 1'b0, 1'b0);
        chk("s8_running", 32'(b8.in_ready), 32'd0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("s8_rst_p",        32'(b8.p),         32'h0000);
        chk("s8_rst_ov",       32'(b8.out_valid), 32'd0);
        chk("s8_rst_in_ready", 32'(b8.in_ready),  32'd1);
        @(negedge clk);
        reset = 1'b0;
        op(8, 8'd200, 8'd3, 1'b0, pr, lat);
        chk("s8_200x3_p",   32'(pr),  32'h0258);
        chk("s8_200x3_lat", 32'(lat), 32'd8);

        // SIZE=5 exhaustive, both modes, back-to-back
        b5.out_ready = 1'b1;
        for (int s = 0; s < 2; s++) begin
            for (int xi = 0; xi < 32; xi++) begin
                for (int yi = 0; yi < 32; yi++) begin
                    xs = (s == 1 && xi >= 16) ? xi - 32 : xi;
                    ys = (s == 1 && yi >= 16) ? yi - 32 : yi;
                    ev = (xs * ys) & 32'h3FF;
                    op(5, 8'(xi), 8'(yi), s[0], pr, lat);
                    chk("exh5_p",   32'(pr),  32'(ev));
                    chk("exh5_lat", 32'(lat), 32'd5);
                end
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
